// File: rtl/mnist_pkg.sv
// Shared image geometry and streamer state encoding for the MNIST front end.
package mnist_pkg;

    localparam int unsigned IMG_WIDTH  = 28;
    localparam int unsigned IMG_HEIGHT = 28;
    localparam int unsigned IMG_X_W    = $clog2(IMG_WIDTH);
    localparam int unsigned IMG_Y_W    = $clog2(IMG_HEIGHT);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

endpackage

// File: rtl/frame_ram.sv
// Binary frame store: synchronous row write, combinational single-bit read, async clear.
module frame_ram #(
    parameter int unsigned WIDTH  = mnist_pkg::IMG_WIDTH,
    parameter int unsigned HEIGHT = mnist_pkg::IMG_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(HEIGHT)-1:0] wr_row,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [$clog2(WIDTH)-1:0]  rd_x,
    input  logic [$clog2(HEIGHT)-1:0] rd_y,
    output logic                      rd_bit_c
);

    logic [WIDTH-1:0] mem [HEIGHT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(HEIGHT); r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    assign rd_bit_c = mem[rd_y][rd_x];

endmodule

// File: rtl/img_pixel_streamer.sv
// Streams a stored binary frame as a gap-free raster of 1-bit pixels with frame markers.
module img_pixel_streamer
    import mnist_pkg::*;
#(
    parameter int unsigned WIDTH  = IMG_WIDTH,
    parameter int unsigned HEIGHT = IMG_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(HEIGHT)-1:0] wr_row,
    input  logic [WIDTH-1:0]          wr_data,
    output logic                      wr_err,
    input  logic                      start,
    output logic                      busy,
    output logic                      pixel_out,
    output logic                      pixel_valid,
    output logic                      sof,
    output logic                      eol,
    output logic                      eof,
    output logic                      done
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);

    stream_state_e state, state_d;
    logic [XW-1:0] x, x_d;
    logic [YW-1:0] y, y_d;
    logic          frame_d, sof_d, eol_d, eof_d, done_d, pix_d, wr_err_d;
    logic          wr_ok, rd_bit_c;

    assign wr_ok = (state == IDLE) && wr_en && (32'(wr_row) < HEIGHT);

    frame_ram #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_frame_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_ok),
        .wr_row   (wr_row),
        .wr_data  (wr_data),
        .rd_x     (x_d),
        .rd_y     (y_d),
        .rd_bit_c (rd_bit_c)
    );

    // Next state, next coordinate and the registered output values that go with it.
    always_comb begin
        state_d  = state;
        x_d      = x;
        y_d      = y;
        frame_d  = 1'b0;
        sof_d    = 1'b0;
        done_d   = 1'b0;
        wr_err_d = wr_en && !wr_ok;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    x_d     = '0;
                    y_d     = '0;
                    frame_d = 1'b1;
                    sof_d   = 1'b1;
                end
            end
            STREAM: begin
                if (eof) begin
                    x_d    = '0;
                    y_d    = '0;
                    done_d = 1'b1;
                    if (start) begin
                        frame_d = 1'b1;
                        sof_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    frame_d = 1'b1;
                    if (x == XW'(WIDTH - 1)) begin
                        x_d = '0;
                        y_d = y + 1'b1;
                    end else begin
                        x_d = x + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        eol_d = frame_d && (x_d == XW'(WIDTH - 1));
        eof_d = eol_d && (y_d == YW'(HEIGHT - 1));
        // A row written on the start edge must already be visible in the first pixel.
        if (wr_ok && (wr_row == y_d)) begin
            pix_d = frame_d && wr_data[x_d];
        end else begin
            pix_d = frame_d && rd_bit_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            busy        <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_out   <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            done        <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            state       <= state_d;
            x           <= x_d;
            y           <= y_d;
            busy        <= frame_d;
            pixel_valid <= frame_d;
            pixel_out   <= pix_d;
            sof         <= sof_d;
            eol         <= eol_d;
            eof         <= eof_d;
            done        <= done_d;
            wr_err      <= wr_err_d;
        end
    end

endmodule

// File: tb/tb_img_pixel_streamer.sv
// Directed self-checking bench for img_pixel_streamer at the default 28x28 geometry.
module tb_img_pixel_streamer;

    localparam int W = 28;
    localparam int H = 28;
    localparam int N = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_row = '0;
    logic [W-1:0]  wr_data = '0;
    logic          start = 1'b0;
    logic          wr_err, busy, pixel_out, pixel_valid, sof, eol, eof, done;
    logic [7:0]    outs;

    logic [W-1:0]  exp_mem [H];
    logic [W-1:0]  rx      [H];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    img_pixel_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .start       (start),
        .busy        (busy),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .sof         (sof),
        .eol         (eol),
        .eof         (eof),
        .done        (done)
    );

    assign outs = {wr_err, busy, pixel_valid, pixel_out, sof, eol, eof, done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] got %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // One frame, starting with pixel 0 already on the outputs; inputs for the next edge are set per pixel.
    task automatic run_frame(input string tag, input int wr_at, input int start_at,
                             input bit hold, input bit next_start, input bit first_done);
        for (int i = 0; i < N; i++) begin
            int x;
            int y;
            logic [7:0] e;
            x = i % W;
            y = i / W;
            e = {(wr_at >= 0) && (i == wr_at + 1), 1'b1, 1'b1, exp_mem[y][x],
                 i == 0, x == W - 1, i == N - 1, first_done && (i == 0)};
            rx[y][x] = pixel_out;
            chk(tag, i, 32'(outs), 32'(e));
            wr_en   = (i == wr_at);
            wr_row  = 5'd5;
            wr_data = '1;
            start   = (hold && i < N - 1) || (i == start_at) || (i == N - 1 && next_start);
            tick();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int hits;
        int mism;
        for (int r = 0; r < H; r++) exp_mem[r] = '0;

        // Reset state
        #2;
        chk("reset_outs", 0, 32'(outs), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_outs", 0, 32'(outs), 32'h0);

        // Load checkerboard
        for (int r = 0; r < H; r++) begin
            wr_en   = 1'b1;
            wr_row  = 5'(r);
            wr_data = (r % 2 == 0) ? 28'h5555555 : 28'hAAAAAAA;
            exp_mem[r] = wr_data;
            tick();
            chk("load_wr_err", r, 32'(wr_err), 32'h0);
        end

        // Out-of-range row in IDLE
        wr_row  = 5'd28;
        wr_data = '1;
        tick();
        wr_en = 1'b0;
        chk("oob_wr_err", 0, 32'(outs), 32'h80);
        tick();
        chk("oob_wr_err_end", 0, 32'(outs), 32'h0);

        // Frame with a rejected write at pixel 50 and an ignored start at pixel 100
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame("frameA", 50, 100, 1'b0, 1'b0, 1'b0);
        chk("frameA_done", 0, 32'(outs), 32'h01);
        // Write in the done cycle is accepted
        wr_en   = 1'b1;
        wr_row  = 5'd3;
        wr_data = 28'h0F0F0F0;
        exp_mem[3] = 28'h0F0F0F0;
        tick();
        wr_en = 1'b0;
        chk("done_cycle_write", 0, 32'(outs), 32'h0);

        // Three back-to-back frames with start held
        start = 1'b1;
        tick();
        run_frame("b2b1", -1, -1, 1'b1, 1'b1, 1'b0);
        run_frame("b2b2", -1, -1, 1'b1, 1'b1, 1'b1);
        run_frame("b2b3", -1, -1, 1'b1, 1'b0, 1'b1);
        start = 1'b0;
        chk("b2b_done", 0, 32'(outs), 32'h01);
        tick();
        chk("b2b_idle", 0, 32'(outs), 32'h0);

        // Write and start on the same edge: pixel (0,0) comes from the new row 0
        wr_en   = 1'b1;
        wr_row  = 5'd0;
        wr_data = 28'h0000001 << 4;
        exp_mem[0] = 28'h0000010;
        start   = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        run_frame("fwd", -1, -1, 1'b0, 1'b0, 1'b0);
        chk("fwd_done", 0, 32'(outs), 32'h01);
        tick();

        // Asynchronous reset mid-frame at pixel 400
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (400) tick();
        chk("pre_rst_valid", 0, 32'(pixel_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", 0, 32'(outs), 32'h0);
        tick();
        rst = 1'b0;
        for (int r = 0; r < H; r++) exp_mem[r] = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame("zero", -1, -1, 1'b0, 1'b0, 1'b0);
        chk("zero_done", 0, 32'(outs), 32'h01);
        tick();

        // Single hot pixel at (10,10) and 3x3 window scan of the received stream
        wr_en   = 1'b1;
        wr_row  = 5'd10;
        wr_data = 28'h0000400;
        exp_mem[10] = 28'h0000400;
        tick();
        wr_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame("hot", -1, -1, 1'b0, 1'b0, 1'b0);
        chk("hot_done", 0, 32'(outs), 32'h01);
        hits = 0;
        mism = 0;
        for (int wy = 0; wy < H - 2; wy++) begin
            for (int wx = 0; wx < W - 2; wx++) begin
                logic has;
                logic want;
                has = 1'b0;
                for (int dy = 0; dy < 3; dy++)
                    for (int dx = 0; dx < 3; dx++)
                        has = has | rx[wy + dy][wx + dx];
                want = (wx >= 8) && (wx <= 10) && (wy >= 8) && (wy <= 10);
                if (has) hits++;
                if (has !== want) mism++;
            end
        end
        chk("win_hits", 0, 32'(hits), 32'd9);
        chk("win_pos_mismatch", 0, 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
